// File: rtl/xor_crypto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_crypto_pkg
// Description : Shared widths and key-state encoding for the 64-bit XOR
//               block encryptor/decryptor pair.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_crypto_pkg;

   localparam int c_DATA_W = 64;   // block and key width
   localparam int c_CNT_W  = 16;   // accepted-block counter width

   // Key state, common to both directions of the link
   typedef enum logic [0:0] {
      NOKEY  = 1'b0,
      ACTIVE = 1'b1
   } dec_state_e;

endpackage : xor_crypto_pkg
`default_nettype wire

// File: rtl/crypto_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_out_reg
// Description : One-entry valid/ready output register with flush. Data is
//               forced to zero whenever the entry is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module crypto_out_reg #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // Flush beats everything; a new load replaces the entry even while it drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_data  <= load_data;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;

endmodule : crypto_out_reg
`default_nettype wire

// File: rtl/xor_block_decryptor.sv
`default_nettype none
// ============================================================================
// Module      : xor_block_decryptor
// Description : Holds a loaded key and turns ciphertext blocks into plaintext
//               (data ^ key) through a one-entry registered output stage.
//               Never accepts or emits data while no key is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_block_decryptor
   import xor_crypto_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int CNT_W  = c_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] key_in,
   input  logic              key_load,
   input  logic              key_clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              key_loaded,
   output logic [CNT_W-1:0]  blk_count
);

   dec_state_e        r_state;
   dec_state_e        w_state_nxt;
   logic [DATA_W-1:0] r_key;
   logic [CNT_W-1:0]  r_count;
   logic              w_accept;
   logic              w_key_evt;

   assign w_key_evt = key_load || key_clear;

   // Blocks are refused in any key-event cycle so no block straddles two keys
   assign in_ready = (r_state == ACTIVE) && !w_key_evt && (!out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Key state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= NOKEY;
      else        r_state <= w_state_nxt;
   end

   // Next key state: clear dominates a simultaneous load
   always_comb begin
      w_state_nxt = r_state;
      if (key_clear)     w_state_nxt = NOKEY;
      else if (key_load) w_state_nxt = ACTIVE;
   end

   // Key register: zeroized on clear, ignoring any load in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_key <= '0;
      else if (key_clear) r_key <= '0;
      else if (key_load)  r_key <= key_in;
   end

   // Accepted-block counter, restarted by any key event, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_count <= '0;
      else if (w_key_evt)                  r_count <= '0;
      else if (w_accept && (r_count != '1)) r_count <= r_count + CNT_W'(1);
   end

   // Output stage; decryption uses the key held before the accepting edge
   crypto_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (key_clear),
      .load      (w_accept),
      .load_data (in_data ^ r_key),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   assign key_loaded = (r_state == ACTIVE);
   assign blk_count  = r_count;

endmodule : xor_block_decryptor
`default_nettype wire

// File: tb/tb_xor_block_decryptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_block_decryptor
// Description : Self-checking bench for xor_block_decryptor. Inputs change on
//               the falling edge; outputs are sampled 1 time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_block_decryptor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] key_in;
   logic        key_load;
   logic        key_clear;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        key_loaded;
   logic [15:0] blk_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   xor_block_decryptor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in),
      .key_load   (key_load),
      .key_clear  (key_clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .key_loaded (key_loaded),
      .blk_count  (blk_count)
   );

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Apply one cycle of inputs on the falling edge, then settle
   task automatic cyc(input logic kl, input logic kc, input logic [63:0] k,
                      input logic iv, input logic [63:0] d, input logic ordy);
      @(negedge clk);
      key_load  = kl;
      key_clear = kc;
      key_in    = k;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b0);
      n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 64'h0)  begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_cmp++; if (key_loaded !== 1'b0) begin n_err++; $display("FAIL reset_key_loaded: got %b want 0", key_loaded); end
      n_cmp++; if (blk_count !== 16'h0) begin n_err++; $display("FAIL reset_blk_count: got %h want 0", blk_count); end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b1);
         n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL nokey_in_ready[%0d]: got %b want 0", i, in_ready); end
         n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL nokey_out_valid[%0d]: got %b want 0", i, out_valid); end
         n_cmp++; if (key_loaded !== 1'b0) begin n_err++; $display("FAIL nokey_key_loaded[%0d]: got %b want 0", i, key_loaded); end
      end
   endtask

   task automatic test_basic();
      cyc(1'b1, 1'b0, 64'h0F0F0F0F0F0F0F0F, 1'b0, '0, 1'b1);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_load_ready: got %b want 0", in_ready); end
      cyc(1'b0, 1'b0, '0, 1'b1, 64'hFFFFFFFF00000000, 1'b1);
      n_cmp++; if (key_loaded !== 1'b1) begin n_err++; $display("FAIL basic_key_loaded: got %b want 1", key_loaded); end
      n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 64'hF0F0F0F00F0F0F0F) begin n_err++; $display("FAIL basic_out_data: got %h want f0f0f0f00f0f0f0f", out_data); end
      n_cmp++; if (blk_count !== 16'd1) begin n_err++; $display("FAIL basic_blk_count: got %0d want 1", blk_count); end
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 64'h0) begin n_err++; $display("FAIL basic_drain_data: got %h want 0", out_data); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] key;
      logic [63:0] blk [5];
      logic [63:0] exp_q [$];
      logic [63:0] e;
      logic        ordy;
      int          idx = 0;
      int          got = 0;
      key = rnd64();
      for (int i = 0; i < 5; i++) blk[i] = rnd64();
      cyc(1'b1, 1'b0, key, 1'b0, '0, 1'b1);
      for (int c = 0; c < 40 && got < 4; c++) begin
         ordy = (c <= 3) ? 1'b0 : 1'b1;
         cyc(1'b0, 1'b0, '0, idx < 4, blk[idx], ordy);
         if (c >= 1 && c <= 3) begin
            n_cmp++; if (out_valid !== 1'b1)          begin n_err++; $display("FAIL b2b_hold_valid[%0d]: got %b want 1", c, out_valid); end
            n_cmp++; if (out_data !== (blk[0] ^ key)) begin n_err++; $display("FAIL b2b_hold_data[%0d]: got %h want %h", c, out_data, blk[0] ^ key); end
            n_cmp++; if (in_ready !== 1'b0)           begin n_err++; $display("FAIL b2b_hold_ready[%0d]: got %b want 0", c, in_ready); end
         end
         if (out_valid === 1'b1 && ordy) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++; $display("FAIL b2b_spurious: out_valid high with nothing outstanding, data %h", out_data);
            end else begin
               e = exp_q.pop_front();
               n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL b2b_order[%0d]: got %h want %h", got, out_data, e); end
               got++;
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(blk[idx] ^ key);
            idx++;
         end
      end
      n_cmp++; if (got != 4) begin n_err++; $display("FAIL b2b_timeout: received %0d want 4", got); end
      n_cmp++; if (blk_count !== 16'd4) begin n_err++; $display("FAIL b2b_blk_count: got %0d want 4", blk_count); end
   endtask

   task automatic test_clear();
      cyc(1'b1, 1'b0, rnd64(), 1'b0, '0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b0);
      cyc(1'b0, 1'b1, '0, 1'b0, '0, 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL clear_pre_valid: got %b want 1", out_valid); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL clear_cycle_ready: got %b want 0", in_ready); end
      cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b0);
      n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL clear_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 64'h0)  begin n_err++; $display("FAIL clear_out_data: got %h want 0", out_data); end
      n_cmp++; if (key_loaded !== 1'b0) begin n_err++; $display("FAIL clear_key_loaded: got %b want 0", key_loaded); end
      n_cmp++; if (blk_count !== 16'h0) begin n_err++; $display("FAIL clear_blk_count: got %h want 0", blk_count); end
      n_cmp++; if (dut.r_key !== 64'h0) begin n_err++; $display("FAIL clear_key_reg: got %h want 0", dut.r_key); end
      // clear and load together from ACTIVE: clear wins
      cyc(1'b1, 1'b0, rnd64(), 1'b0, '0, 1'b1);
      cyc(1'b1, 1'b1, rnd64(), 1'b0, '0, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b1);
      n_cmp++; if (key_loaded !== 1'b0) begin n_err++; $display("FAIL both_key_loaded: got %b want 0", key_loaded); end
      n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL both_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (dut.r_key !== 64'h0) begin n_err++; $display("FAIL both_key_reg: got %h want 0", dut.r_key); end
   endtask

   task automatic test_rekey();
      cyc(1'b1, 1'b0, rnd64(), 1'b0, '0, 1'b1);
      cyc(1'b1, 1'b0, {16{4'hA}}, 1'b1, rnd64(), 1'b1);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rekey_cycle_ready: got %b want 0", in_ready); end
      cyc(1'b0, 1'b0, '0, 1'b1, {16{4'hA}}, 1'b1);
      n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rekey_next_ready: got %b want 1", in_ready); end
      n_cmp++; if (blk_count !== 16'h0) begin n_err++; $display("FAIL rekey_count_reset: got %0d want 0", blk_count); end
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      n_cmp++; if (out_valid !== 1'b1)  begin n_err++; $display("FAIL rekey_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 64'h0)  begin n_err++; $display("FAIL rekey_out_data: got %h want 0", out_data); end
      n_cmp++; if (blk_count !== 16'd1) begin n_err++; $display("FAIL rekey_blk_count: got %0d want 1", blk_count); end
   endtask

   // Random traffic against a transaction-level model: a key, a pending slot, a count
   task automatic test_random();
      logic [63:0] m_key, m_data, k, d;
      logic        m_active, m_pend, kl, kc, iv, ordy, exp_rdy;
      int          m_cnt;
      m_key = rnd64();
      cyc(1'b1, 1'b0, m_key, 1'b0, '0, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      m_active = 1'b1; m_pend = 1'b0; m_data = '0; m_cnt = 0;
      for (int i = 0; i < 1500; i++) begin
         kl = ($urandom_range(0, 39) == 0);
         kc = ($urandom_range(0, 79) == 0);
         k = rnd64(); d = rnd64();
         iv = $urandom_range(0, 3) != 0;
         ordy = $urandom_range(0, 2) != 0;
         cyc(kl, kc, k, iv, d, ordy);
         exp_rdy = m_active && !kl && !kc && (!m_pend || ordy);
         n_cmp++; if (in_ready !== exp_rdy)  begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, exp_rdy); end
         n_cmp++; if (out_valid !== m_pend)  begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, out_valid, m_pend); end
         n_cmp++; if (out_data !== (m_pend ? m_data : 64'h0)) begin n_err++; $display("FAIL rnd_out_data[%0d]: got %h want %h", i, out_data, m_pend ? m_data : 64'h0); end
         n_cmp++; if (blk_count !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_blk_count[%0d]: got %0d want %0d", i, blk_count, m_cnt); end
         n_cmp++; if (key_loaded !== m_active) begin n_err++; $display("FAIL rnd_key_loaded[%0d]: got %b want %b", i, key_loaded, m_active); end
         if (kc) begin
            m_active = 1'b0; m_key = '0; m_pend = 1'b0; m_data = '0; m_cnt = 0;
         end else if (kl) begin
            m_active = 1'b1; m_key = k; m_cnt = 0;
            if (m_pend && ordy) m_pend = 1'b0;
         end else if (iv && exp_rdy) begin
            m_pend = 1'b1; m_data = d ^ m_key;
            if (m_cnt < 65535) m_cnt++;
         end else if (m_pend && ordy) begin
            m_pend = 1'b0;
         end
      end
   endtask

   task automatic test_saturation();
      cyc(1'b1, 1'b0, rnd64(), 1'b0, '0, 1'b1);
      for (int i = 0; i < 65535; i++) cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b1);
      n_cmp++; if (blk_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %h want ffff", blk_count); end
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, 1'b1, rnd64(), 1'b1);
      n_cmp++; if (blk_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", blk_count); end
      n_cmp++; if (out_valid !== 1'b1)     begin n_err++; $display("FAIL sat_streaming: got %b want 1", out_valid); end
      // asynchronous reset between clock edges
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 64'h0)  begin n_err++; $display("FAIL arst_out_data: got %h want 0", out_data); end
      n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (key_loaded !== 1'b0) begin n_err++; $display("FAIL arst_key_loaded: got %b want 0", key_loaded); end
      n_cmp++; if (blk_count !== 16'h0) begin n_err++; $display("FAIL arst_blk_count: got %h want 0", blk_count); end
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; key_in = '0; key_load = 1'b0; key_clear = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_clear();
      test_rekey();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_xor_block_decryptor
`default_nettype wire
